instr_fetch: RTL
================

Name: instr_fetch

Overview:
- IF stage of the veriRISCV 5-stage core, directly upstream of instruction decode.
- Owns the fetch PC and drives a single-outstanding request/grant/response instruction-memory port.
- Presents if_pc/if_instruction/if_valid to ID through a pipeline register, and honours ID stall and EX branch/jump redirect.
- Includes a one-entry skid buffer, so a response that arrives during a stall is never lost.

Parameters:
- PC_WIDTH, 32, width of PC and imem address.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instruction when not valid (addi x0,x0,0).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- stall, input, 1, ID/hazard unit holds the IF/ID register.
- redirect, input, 1, EX branch taken or jump.
- redirect_pc, input, PC_WIDTH, new fetch target.
- imem_req, output, 1, fetch request.
- imem_addr, output, PC_WIDTH, request address (word aligned).
- imem_gnt, input, 1, request accepted this cycle.
- imem_rvalid, input, 1, response valid; arrives at least 1 cycle after grant.
- imem_rdata, input, DATA_WIDTH, fetched instruction.
- if_valid, output, 1, IF/ID register holds a live instruction.
- if_pc, output, PC_WIDTH, PC of if_instruction.
- if_instruction, output, DATA_WIDTH, instruction to decoder.

Behaviour:
- Reset (sync, active-high): fetch_pc=RESET_PC, state=REQ, kill=0, skid empty, if_valid=0, if_pc=0, if_instruction=NOP_INSTR, imem_req=0 during the reset cycle.
- States:
  - REQ: no request outstanding.
  - WAIT: one request granted, response pending.
- Request issue: imem_req=1 with imem_addr=fetch_pc when all of the following hold:
  - state=REQ, or state=WAIT with imem_rvalid=1 in this cycle (back-to-back, 1 instr/cycle with a 1-cycle memory).
  - Skid buffer empty.
  - redirect=0.
- Grant: on imem_req&imem_gnt, fetch_pc<=fetch_pc+4 (wraps modulo 2^PC_WIDTH) and state<=WAIT. Without a grant, imem_addr is held stable until granted.
- Response in WAIT (imem_rvalid=1):
  - kill=1: discard the data, clear kill.
  - Otherwise, if the output register is free (!if_valid | !stall): load if_pc/if_instruction, set if_valid=1. The response PC is tracked in a req_pc register.
  - Otherwise: write the skid buffer.
  - If no new grant occurs in the same cycle, state<=REQ.
- Output drain: when if_valid & !stall and the skid is full, the skid moves into the output register and the skid empties. When if_valid & !stall and the skid is empty with no response, if_valid<=0 and if_instruction<=NOP_INSTR.
- Stall: when if_valid=1 and stall=1, if_pc/if_instruction/if_valid hold. stall with if_valid=0 has no effect.
- Redirect (highest priority, overrides stall and rvalid):
  - fetch_pc<=redirect_pc with bits[1:0] forced to 0; the misaligned-target exception belongs to EX.
  - if_valid<=0, skid cleared, imem_req=0 in the redirect cycle.
  - If state=WAIT and imem_rvalid=0: kill<=1, state stays WAIT.
  - If state=WAIT and imem_rvalid=1: response dropped, state<=REQ.
  - The first request to the new target is issued the cycle after redirect (REQ) or the cycle after the killed response returns.
- Redirect during reset: ignored; rst wins.
- Latency: redirect -> imem_req at target, 1 cycle. Response -> if_valid, 1 cycle (registered).
- Invariants: at most one outstanding request; exactly one of {output, skid, discard} consumes every response.

Decomposition:
- Shared package/header core.vh holds:
  - NOP_INSTR constant.
  - PC_RANGE/DATA_RANGE macros, already used by ID.
  - Fetch state encodings IF_REQ/IF_WAIT.
- One sub-module: if_skid_buf, a 1-entry {pc,instr} buffer with push/pop/flush/full.

Test Plan:
- Reset, memory grants immediately with 1-cycle rvalid, 0x13,0x93,... at 0x0,0x4,0x8 -> if_valid high from cycle 3, if_pc 0,4,8 on consecutive cycles, imem_req continuous.
- stall=1 for 3 cycles while a response arrives -> if_pc holds 0x4, skid captures 0x8. After release, 0x8 appears next cycle with no duplicate/loss and no request issued while the skid is full.
- redirect=1 redirect_pc=0x100 while a request to 0xC is outstanding (rvalid 2 cycles later) -> 0xC response dropped, if_valid=0 next cycle, next imem_addr=0x100, if_pc=0x100 appears.
- redirect together with stall=1 and if_valid=1 -> if_valid cleared next cycle (redirect wins), skid flushed.
- imem_gnt held 0 for 4 cycles -> imem_req stays 1 with imem_addr stable at 0x10, if_valid drops to 0 after drain; redirect_pc=0x203 -> imem_addr=0x200.
- rst asserted mid-WAIT -> next cycle if_valid=0, if_instruction=0x13, then a fetch from RESET_PC with the late response (kill/reset) ignored.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions.
// Contents:
//   NOP_INSTR_DEF  - canonical bubble instruction (addi x0,x0,0)
//   fetch_state_t  - fetch FSM encoding (IF_REQ / IF_WAIT)
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic {
        IF_REQ  = 1'b0,
        IF_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer that catches a fetch response
// arriving while the IF/ID register is stalled.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, push_pc,
//   push_instr        - capture an entry
//   pop               - release the entry to the IF/ID register
//   flush             - drop the entry (redirect)
//   full              - entry is occupied
//   pc, instr         - stored entry
module instr_fetch_skid_buf #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    output logic                  full,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [DATA_WIDTH-1:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full  <= 1'b1;
            pc    <= push_pc;
            instr <= push_instr;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, drives a single-outstanding
// req/gnt/rvalid instruction memory port and presents fetched instructions
// to decode through the IF/ID register. Honours decode stall and EX redirect.
//
//   state   | meaning
//   --------+-----------------------------------------
//   IF_REQ  | no request outstanding
//   IF_WAIT | one request granted, response pending
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   stall                    - hold the IF/ID register
//   redirect, redirect_pc    - branch/jump redirect from EX
//   imem_req, imem_addr      - fetch request (address word aligned)
//   imem_gnt                 - request accepted this cycle
//   imem_rvalid, imem_rdata  - fetch response
//   if_valid, if_pc,
//   if_instruction           - IF/ID register contents
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                   PC_WIDTH   = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic [DATA_WIDTH-1:0] if_instruction
);

    fetch_state_t          state, state_next;
    logic                  kill, kill_next;
    logic [PC_WIDTH-1:0]   fetch_pc, fetch_pc_next;
    logic [PC_WIDTH-1:0]   req_pc, req_pc_next;
    logic                  valid_next;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [DATA_WIDTH-1:0] instr_next;

    logic                  resp, resp_live, out_free, grant;
    logic                  skid_push, skid_pop, skid_full;
    logic [PC_WIDTH-1:0]   skid_pc;
    logic [DATA_WIDTH-1:0] skid_instr;

    instr_fetch_skid_buf #(
        .PC_WIDTH   (PC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (skid_push),
        .pop        (skid_pop),
        .flush      (redirect),
        .push_pc    (req_pc),
        .push_instr (imem_rdata),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign imem_addr = fetch_pc;

    always_comb begin
        resp      = (state == IF_WAIT) && imem_rvalid;
        resp_live = resp && !kill;
        out_free  = !if_valid || !stall;

        // Back-to-back issue only when this cycle's response lands in the
        // output register; a response headed for the skid must be the last
        // one in flight, otherwise the next could arrive with nowhere to go.
        imem_req  = !rst && !redirect && !skid_full &&
                    ((state == IF_REQ) || (resp_live && out_free));
        grant     = imem_req && imem_gnt;
        skid_push = resp_live && !out_free && !redirect;
        skid_pop  = if_valid && !stall && skid_full && !redirect;

        state_next    = state;
        kill_next     = kill;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        valid_next    = if_valid;
        pc_next       = if_pc;
        instr_next    = if_instruction;

        if (redirect) begin
            fetch_pc_next = redirect_pc & ~PC_WIDTH'(3);
            valid_next    = 1'b0;
            instr_next    = NOP_INSTR;
            // An in-flight request cannot be cancelled on the bus, so its
            // response is marked for discard and we keep waiting for it.
            if ((state == IF_WAIT) && !imem_rvalid) begin
                kill_next  = 1'b1;
                state_next = IF_WAIT;
            end else begin
                kill_next  = 1'b0;
                state_next = IF_REQ;
            end
        end else begin
            if (grant) begin
                fetch_pc_next = fetch_pc + PC_WIDTH'(4);
                req_pc_next   = fetch_pc;
                state_next    = IF_WAIT;
            end else if (resp) begin
                state_next = IF_REQ;
            end
            if (resp) begin
                kill_next = 1'b0;
            end

            // The skid is only ever full while no request is outstanding,
            // so a live response and a skid drain never coincide.
            if (resp_live && out_free) begin
                valid_next = 1'b1;
                pc_next    = req_pc;
                instr_next = imem_rdata;
            end else if (if_valid && !stall) begin
                if (skid_full) begin
                    pc_next    = skid_pc;
                    instr_next = skid_instr;
                end else begin
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IF_REQ;
            kill           <= 1'b0;
            fetch_pc       <= RESET_PC;
            req_pc         <= '0;
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_instruction <= NOP_INSTR;
        end else begin
            state          <= state_next;
            kill           <= kill_next;
            fetch_pc       <= fetch_pc_next;
            req_pc         <= req_pc_next;
            if_valid       <= valid_next;
            if_pc          <= pc_next;
            if_instruction <= instr_next;
        end
    end

endmodule
